// File: rtl/avr_spi_pkg.sv
// Shared types and helpers for the AVR-compatible SPI block (master and slave paths).
package avr_spi_pkg;

  typedef struct packed {
    logic       spe;
    logic       dord;
    logic       mstr;
    logic       cpol;
    logic       cpha;
    logic [1:0] spr;
  } spcr_t;

  typedef enum logic [1:0] {
    MstrIdle,
    MstrSetup,
    MstrShift,
    MstrDone
  } mstr_state_t;

  // SCK half-period in core clock cycles, indexed by {SPI2X, SPR}.
  function automatic logic [6:0] spi_half_period(input logic spi2x, input logic [1:0] spr);
    logic [6:0] h;
    case ({spi2x, spr})
      3'b000:  h = 7'd2;
      3'b001:  h = 7'd8;
      3'b010:  h = 7'd32;
      3'b011:  h = 7'd64;
      3'b100:  h = 7'd1;
      3'b101:  h = 7'd4;
      3'b110:  h = 7'd16;
      default: h = 7'd32;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/avr_spi_mstr_clkgen.sv
// SCK generator for the SPI master: half-period divider, SCK toggle flop and edge counter.
// lead_o/trail_o/last_o pulse in the cycle an edge is generated; SCK shows it one cycle later.
module avr_spi_mstr_clkgen
  import avr_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       run_i,
  input  logic       cpol_i,
  input  logic [6:0] half_i,
  output logic       sck_o,
  output logic       lead_o,
  output logic       trail_o,
  output logic       last_o
);

  logic [5:0] reload_q;
  logic [5:0] cnt_q;
  logic [3:0] edge_q;
  logic       sck_q;
  logic       expire;

  assign expire  = run_i && (cnt_q == 6'd0);
  assign lead_o  = expire && !edge_q[0];
  assign trail_o = expire && edge_q[0];
  assign last_o  = expire && (edge_q == 4'd15);
  assign sck_o   = sck_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= 6'd0;
      cnt_q    <= 6'd0;
      edge_q   <= 4'd0;
      sck_q    <= 1'b0;
    end else if (start_i) begin
      reload_q <= 6'(half_i - 7'd1);
      cnt_q    <= 6'(half_i - 7'd1);
      edge_q   <= 4'd0;
      sck_q    <= cpol_i;
    end else if (expire) begin
      cnt_q  <= reload_q;
      edge_q <= edge_q + 4'd1;
      sck_q  <= ~sck_q;
    end else if (run_i) begin
      cnt_q <= cnt_q - 6'd1;
    end else begin
      // Idle (or aborting): SCK tracks the live CPOL.
      sck_q <= cpol_i;
    end
  end

endmodule

// File: rtl/avr_spi_mstr_xfer.sv
// Master-side SPI shift engine in the core clock domain: one byte per accepted start.
// AVR_SPI_MSTR_DORD_EN builds LSB-first support; without it transfers are always MSB first.
module avr_spi_mstr_xfer
  import avr_spi_pkg::*;
#(
  parameter logic IDLE_MOSI = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  spcr_t      core_mstr_spcr,
  input  logic       core_mstr_spi2x,
  input  logic       core_mstr_start,
  input  logic [7:0] core_mstr_txd,
  input  logic       misoi,
  output logic       scko,
  output logic       mosio,
  output logic [7:0] mstr_core_rxd,
  output logic       mstr_core_done,
  output logic       mstr_core_busy,
  output logic       mstr_core_wcol
);

  mstr_state_t state_q;
  logic [7:0]  sh_q;
  logic [7:0]  rxd_q;
  logic        mosi_q, done_q, busy_q, wcol_q, cpha_q, rxbit_q;
  logic        enabled, accept, running, lead, trail, last;
  logic        rx_in, first_bit, out_bit, next_bit;
  logic [7:0]  sh_shift;

  assign enabled = core_mstr_spcr.spe && core_mstr_spcr.mstr;
  assign accept  = core_mstr_start && enabled && (state_q == MstrIdle);
  assign running = ((state_q == MstrSetup) || (state_q == MstrShift)) && core_mstr_spcr.spe;
  // CPHA=0 samples on the leading edge and shifts on the trailing one.
  assign rx_in   = cpha_q ? misoi : rxbit_q;

`ifdef AVR_SPI_MSTR_DORD_EN
  logic dord_q;
  assign first_bit = core_mstr_spcr.dord ? core_mstr_txd[0] : core_mstr_txd[7];
  assign out_bit   = dord_q ? sh_q[0] : sh_q[7];
  assign next_bit  = dord_q ? sh_q[1] : sh_q[6];
  assign sh_shift  = dord_q ? {rx_in, sh_q[7:1]} : {sh_q[6:0], rx_in};
`else
  logic unused_dord;
  assign unused_dord = core_mstr_spcr.dord;
  assign first_bit   = core_mstr_txd[7];
  assign out_bit     = sh_q[7];
  assign next_bit    = sh_q[6];
  assign sh_shift    = {sh_q[6:0], rx_in};
`endif

  avr_spi_mstr_clkgen u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .run_i   (running),
    .cpol_i  (core_mstr_spcr.cpol),
    .half_i  (spi_half_period(core_mstr_spi2x, core_mstr_spcr.spr)),
    .sck_o   (scko),
    .lead_o  (lead),
    .trail_o (trail),
    .last_o  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MstrIdle;
      sh_q    <= 8'h00;
      rxd_q   <= 8'h00;
      mosi_q  <= IDLE_MOSI;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wcol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      rxbit_q <= 1'b0;
`ifdef AVR_SPI_MSTR_DORD_EN
      dord_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      wcol_q <= core_mstr_start && enabled && (state_q != MstrIdle);
      unique case (state_q)
        MstrIdle: begin
          if (accept) begin
            state_q <= MstrSetup;
            busy_q  <= 1'b1;
            cpha_q  <= core_mstr_spcr.cpha;
            sh_q    <= core_mstr_txd;
            mosi_q  <= core_mstr_spcr.cpha ? IDLE_MOSI : first_bit;
`ifdef AVR_SPI_MSTR_DORD_EN
            dord_q  <= core_mstr_spcr.dord;
`endif
          end
        end
        MstrSetup, MstrShift: begin
          if (!core_mstr_spcr.spe) begin
            state_q <= MstrIdle;
            busy_q  <= 1'b0;
            mosi_q  <= IDLE_MOSI;
          end else begin
            if (lead) begin
              if (cpha_q) mosi_q <= out_bit;
              else        rxbit_q <= misoi;
            end
            if (trail) begin
              sh_q <= sh_shift;
              if (!cpha_q && !last) mosi_q <= next_bit;
            end
            if (last)      state_q <= MstrDone;
            else if (lead) state_q <= MstrShift;
          end
        end
        MstrDone: begin
          state_q <= MstrIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          rxd_q   <= sh_q;
          mosi_q  <= IDLE_MOSI;
        end
        default: state_q <= MstrIdle;
      endcase
    end
  end

  assign mosio          = mosi_q;
  assign mstr_core_rxd  = rxd_q;
  assign mstr_core_done = done_q;
  assign mstr_core_busy = busy_q;
  assign mstr_core_wcol = wcol_q;

endmodule

// File: tb/tb_avr_spi_mstr_xfer.sv
// Directed bench for avr_spi_mstr_xfer; DORD expectations follow AVR_SPI_MSTR_DORD_EN.
module tb_avr_spi_mstr_xfer;
  import avr_spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  spcr_t      spcr;
  logic       spi2x, start, miso_drv, loop_en, misoi;
  logic [7:0] txd;
  logic       scko, mosio, done, busy, wcol;
  logic [7:0] rxd;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations recorded by xfer for each transfer (cycle 1 = first cycle after the start).
  int         edge_cyc[16];
  int         n_edges, done_cyc, busy_gaps, wcol_cnt, wcol_cyc;
  logic [7:0] mosi_cap, rxd_cap;
  logic       sck_init, busy_at_done;
  logic [7:0] last_rxd;

  always #5 clk = ~clk;
  assign misoi = loop_en ? mosio : miso_drv;

  avr_spi_mstr_xfer dut (
    .clk             (clk),
    .rst             (rst),
    .core_mstr_spcr  (spcr),
    .core_mstr_spi2x (spi2x),
    .core_mstr_start (start),
    .core_mstr_txd   (txd),
    .misoi           (misoi),
    .scko            (scko),
    .mosio           (mosio),
    .mstr_core_rxd   (rxd),
    .mstr_core_done  (done),
    .mstr_core_busy  (busy),
    .mstr_core_wcol  (wcol)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic spcr_t mk_spcr(input logic cpol, input logic cpha, input logic dord,
                                    input logic [1:0] spr);
    spcr_t s;
    s.spe = 1'b1; s.mstr = 1'b1; s.cpol = cpol; s.cpha = cpha; s.dord = dord; s.spr = spr;
    return s;
  endfunction

  // Runs one transfer, called at a negedge; returns at the negedge of the done cycle.
  task automatic xfer(input logic [7:0] tx, input int h, input logic [7:0] miso_byte,
                      input int extra_at);
    logic prev;
    int n, k, e;
    n_edges = 0; done_cyc = -1; busy_gaps = 0; wcol_cnt = 0; wcol_cyc = -1;
    mosi_cap = 8'h00; rxd_cap = 8'h00; busy_at_done = 1'b1;
    for (int i = 0; i < 16; i++) edge_cyc[i] = -1;
    prev = scko; txd = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1; sck_init = scko;
    while (done_cyc < 0 && n <= 16 * h + 8) begin
      if (scko !== prev) begin
        if (n_edges < 16) edge_cyc[n_edges] = n;
        n_edges++; prev = scko;
      end
      if (wcol === 1'b1) begin wcol_cnt++; wcol_cyc = n; end
      if (busy !== 1'b1 && done !== 1'b1) busy_gaps++;
      if (done === 1'b1) begin done_cyc = n; rxd_cap = rxd; busy_at_done = busy; end
      k = n / h;
      if (n % h == 0 && k >= 1 && k <= 16 && ((k % 2 == 1) == (spcr.cpha == 1'b0)))
        mosi_cap[7 - (k - 1) / 2] = mosio;
      e = (n - 1) / h;
      miso_drv = miso_byte[7 - ((e / 2 > 7) ? 7 : e / 2)];
      if (done_cyc < 0) begin
        start = (n == extra_at);
        if (start) txd = ~tx;
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    spcr = mk_spcr(1'b1, 1'b0, 1'b0, 2'b00); spi2x = 1'b0; start = 1'b0; txd = 8'h00;
    loop_en = 1'b0; miso_drv = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (scko !== 1'b0) begin n_fail++; $display("FAIL reset_scko got=%b want=0", scko); end
    n_checks++; if (mosio !== 1'b1) begin n_fail++; $display("FAIL reset_mosi got=%b want=1", mosio); end
    n_checks++; if (rxd !== 8'h00) begin n_fail++; $display("FAIL reset_rxd got=%h want=00", rxd); end
    n_checks++;
    if ({done, busy, wcol} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=000", {done, busy, wcol});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (scko !== 1'b1) begin n_fail++; $display("FAIL idle_cpol1 got=%b want=1", scko); end
    spcr.cpol = 1'b0;
    @(negedge clk);
    n_checks++; if (scko !== 1'b0) begin n_fail++; $display("FAIL idle_cpol0 got=%b want=0", scko); end
  endtask

  task automatic test_enable;
    spcr = mk_spcr(1'b0, 1'b0, 1'b0, 2'b00); spcr.mstr = 1'b0;
    txd = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, wcol} !== 2'b00) begin
      n_fail++; $display("FAIL mstr0_start got=%b want=00", {busy, wcol});
    end
    spcr = mk_spcr(1'b0, 1'b0, 1'b0, 2'b00); spcr.spe = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, wcol} !== 2'b00) begin
      n_fail++; $display("FAIL spe0_start got=%b want=00", {busy, wcol});
    end
    spcr.spe = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0;
    spcr = mk_spcr(1'b0, 1'b0, 1'b0, 2'b00); spi2x = 1'b0; loop_en = 1'b1;
    xfer(8'hA5, 2, 8'h00, -1);
    n_checks++; if (sck_init !== 1'b0) begin n_fail++; $display("FAIL m0_sck_idle got=%b want=0", sck_init); end
    n_checks++; if (n_edges !== 16) begin n_fail++; $display("FAIL m0_edges got=%0d want=16", n_edges); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (edge_cyc[i] !== 3 + 2 * i) begin
        n_fail++; $display("FAIL m0_edge%0d got=%0d want=%0d", i + 1, edge_cyc[i], 3 + 2 * i);
      end
    end
    n_checks++; if (done_cyc !== 34) begin n_fail++; $display("FAIL m0_done_cyc got=%0d want=34", done_cyc); end
    n_checks++; if (rxd_cap !== 8'hA5) begin n_fail++; $display("FAIL m0_rxd got=%h want=a5", rxd_cap); end
    n_checks++; if (mosi_cap !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi got=%h want=a5", mosi_cap); end
    n_checks++; if (busy_gaps !== 0) begin n_fail++; $display("FAIL m0_busy_gaps got=%0d want=0", busy_gaps); end
    n_checks++;
    if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL m0_busy_at_done got=%b want=0", busy_at_done); end
    n_checks++; if (wcol_cnt !== 0) begin n_fail++; $display("FAIL m0_wcol got=%0d want=0", wcol_cnt); end
    last_rxd = 8'hA5;
  endtask

  task automatic test_mode3;
    spcr = mk_spcr(1'b1, 1'b1, 1'b0, 2'b11); spi2x = 1'b0; loop_en = 1'b0;
    repeat (2) @(negedge clk);
    xfer(8'h3C, 64, 8'hC3, -1);
    n_checks++; if (sck_init !== 1'b1) begin n_fail++; $display("FAIL m3_sck_idle got=%b want=1", sck_init); end
    n_checks++; if (n_edges !== 16) begin n_fail++; $display("FAIL m3_edges got=%0d want=16", n_edges); end
    n_checks++; if (edge_cyc[0] !== 65) begin n_fail++; $display("FAIL m3_edge1 got=%0d want=65", edge_cyc[0]); end
    n_checks++;
    if (edge_cyc[2] - edge_cyc[0] !== 128) begin
      n_fail++; $display("FAIL m3_period got=%0d want=128", edge_cyc[2] - edge_cyc[0]);
    end
    n_checks++; if (edge_cyc[15] !== 1025) begin n_fail++; $display("FAIL m3_edge16 got=%0d want=1025", edge_cyc[15]); end
    n_checks++; if (done_cyc !== 1026) begin n_fail++; $display("FAIL m3_done_cyc got=%0d want=1026", done_cyc); end
    n_checks++; if (rxd_cap !== 8'hC3) begin n_fail++; $display("FAIL m3_rxd got=%h want=c3", rxd_cap); end
    n_checks++; if (mosi_cap !== 8'h3C) begin n_fail++; $display("FAIL m3_mosi got=%h want=3c", mosi_cap); end
    n_checks++; if (busy_gaps !== 0) begin n_fail++; $display("FAIL m3_busy_gaps got=%0d want=0", busy_gaps); end
    repeat (2) @(negedge clk);
    n_checks++; if (scko !== 1'b1) begin n_fail++; $display("FAIL m3_sck_after got=%b want=1", scko); end
    last_rxd = 8'hC3;
  endtask

  task automatic test_dord;
    logic [7:0] exp_mosi;
`ifdef AVR_SPI_MSTR_DORD_EN
    exp_mosi = 8'h80;
`else
    exp_mosi = 8'h01;
`endif
    spcr = mk_spcr(1'b0, 1'b1, 1'b1, 2'b00); spi2x = 1'b1; loop_en = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'h01, 1, 8'h00, -1);
    n_checks++; if (n_edges !== 16) begin n_fail++; $display("FAIL d_edges got=%0d want=16", n_edges); end
    n_checks++; if (edge_cyc[0] !== 2) begin n_fail++; $display("FAIL d_edge1 got=%0d want=2", edge_cyc[0]); end
    n_checks++; if (done_cyc !== 18) begin n_fail++; $display("FAIL d_done_cyc got=%0d want=18", done_cyc); end
    n_checks++; if (mosi_cap !== exp_mosi) begin n_fail++; $display("FAIL d_mosi got=%h want=%h", mosi_cap, exp_mosi); end
    n_checks++; if (rxd_cap !== 8'h01) begin n_fail++; $display("FAIL d_rxd got=%h want=01", rxd_cap); end
    last_rxd = 8'h01;
    spi2x = 1'b0;
  endtask

  task automatic test_back_to_back;
    spcr = mk_spcr(1'b0, 1'b0, 1'b0, 2'b00); spi2x = 1'b0; loop_en = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'h96, 2, 8'h00, 11);
    n_checks++; if (wcol_cnt !== 1) begin n_fail++; $display("FAIL b_wcol_cnt got=%0d want=1", wcol_cnt); end
    n_checks++; if (wcol_cyc !== 12) begin n_fail++; $display("FAIL b_wcol_cyc got=%0d want=12", wcol_cyc); end
    n_checks++; if (done_cyc !== 34) begin n_fail++; $display("FAIL b_done_cyc got=%0d want=34", done_cyc); end
    n_checks++; if (rxd_cap !== 8'h96) begin n_fail++; $display("FAIL b_rxd got=%h want=96", rxd_cap); end
    n_checks++; if (mosi_cap !== 8'h96) begin n_fail++; $display("FAIL b_mosi got=%h want=96", mosi_cap); end
    xfer(8'h3C, 2, 8'h00, 33);
    n_checks++; if (wcol_cyc !== 34) begin n_fail++; $display("FAIL b_wcol_done got=%0d want=34", wcol_cyc); end
    n_checks++; if (rxd_cap !== 8'h3C) begin n_fail++; $display("FAIL b_rxd2 got=%h want=3c", rxd_cap); end
    xfer(8'hC5, 2, 8'h00, -1);
    n_checks++; if (done_cyc !== 34) begin n_fail++; $display("FAIL b_next_done got=%0d want=34", done_cyc); end
    n_checks++; if (busy_gaps !== 0) begin n_fail++; $display("FAIL b_next_busy got=%0d want=0", busy_gaps); end
    n_checks++; if (rxd_cap !== 8'hC5) begin n_fail++; $display("FAIL b_rxd3 got=%h want=c5", rxd_cap); end
    last_rxd = 8'hC5;
  endtask

  task automatic test_abort;
    int done_seen;
    spcr = mk_spcr(1'b0, 1'b0, 1'b0, 2'b00); loop_en = 1'b1;
    repeat (2) @(negedge clk);
    txd = 8'h81; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 15; n++) @(negedge clk);
    n_checks++; if (scko !== 1'b1) begin n_fail++; $display("FAIL a_sck_edge7 got=%b want=1", scko); end
    spcr.spe = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a_busy got=%b want=0", busy); end
    n_checks++; if (scko !== 1'b0) begin n_fail++; $display("FAIL a_sck got=%b want=0", scko); end
    n_checks++; if (mosio !== 1'b1) begin n_fail++; $display("FAIL a_mosi got=%b want=1", mosio); end
    done_seen = 0;
    repeat (40) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL a_done got=%0d want=0", done_seen); end
    n_checks++; if (rxd !== last_rxd) begin n_fail++; $display("FAIL a_rxd got=%h want=%h", rxd, last_rxd); end
    spcr.spe = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    spcr = mk_spcr(1'b1, 1'b0, 1'b0, 2'b00); loop_en = 1'b1;
    repeat (2) @(negedge clk);
    txd = 8'hD0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (scko !== 1'b0) begin n_fail++; $display("FAIL r_sck got=%b want=0", scko); end
    n_checks++; if (mosio !== 1'b1) begin n_fail++; $display("FAIL r_mosi got=%b want=1", mosio); end
    n_checks++; if (rxd !== 8'h00) begin n_fail++; $display("FAIL r_rxd got=%h want=00", rxd); end
    n_checks++;
    if ({done, busy, wcol} !== 3'b000) begin
      n_fail++; $display("FAIL r_flags got=%b want=000", {done, busy, wcol});
    end
    @(negedge clk);
    n_checks++; if (scko !== 1'b1) begin n_fail++; $display("FAIL r_sck_cpol got=%b want=1", scko); end
    xfer(8'h5A, 2, 8'h00, -1);
    n_checks++; if (sck_init !== 1'b1) begin n_fail++; $display("FAIL r_sck_idle got=%b want=1", sck_init); end
    n_checks++; if (done_cyc !== 34) begin n_fail++; $display("FAIL r_done_cyc got=%0d want=34", done_cyc); end
    n_checks++; if (rxd_cap !== 8'h5A) begin n_fail++; $display("FAIL r_rxd2 got=%h want=5a", rxd_cap); end
    n_checks++; if (mosi_cap !== 8'h5A) begin n_fail++; $display("FAIL r_mosi2 got=%h want=5a", mosi_cap); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_mode0();
    test_mode3();
    test_dord();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
